// File: rtl/dma_request_agent_pkg.sv
// Shared types and default sizing for the DMA request agent.
// Holds the handshake state encoding used by the agent and any tooling that observes it.
package dmaAgentPkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } agentState_t;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_FIFO_DEPTH   = 4;
  localparam int DEFAULT_BLOCK_THRESH = 4;

endpackage

// File: rtl/dma_agent_fifo.sv
// Word buffer between the peripheral and the DMA bus side of the request agent.
// A pop frees a slot in the same cycle, so a push into a full FIFO alongside a pop is accepted.
module dma_agent_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rdPtr;
  logic [PTR_W-1:0]      wrPtr;
  logic                  doPush;
  logic                  doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = empty ? '0 : mem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; head is masked to zero while empty so stale words never show.
  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/dma_request_agent.sv
// Peripheral-side DMA request agent: buffers pushed words and runs the DREQ/DACK handshake,
// presenting one word per IOR strobe in single or block mode.
module dma_request_agent
  import dmaAgentPkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int BLOCK_THRESH = DEFAULT_BLOCK_THRESH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  wrEn,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  blockMode,
  input  logic                  DACK,
  input  logic                  IOR,
  input  logic                  EOP,
  output logic                  DREQ,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutEn,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [7:0]            xferCount
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  agentState_t      state;
  logic             blockLatched;
  logic [CNT_W-1:0] fifoCount;
  logic             doPop;
  logic             startReq;
  logic             lastWord;
  logic             pushDropped;

  dma_agent_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (wrEn),
    .pushData(wrData),
    .pop     (doPop),
    .head    (dataOut),
    .full    (full),
    .empty   (empty),
    .count   (fifoCount)
  );

  assign dataOutEn   = (state == ACK) && DACK;
  assign doPop       = dataOutEn && IOR && !empty;
  assign pushDropped = wrEn && full && !doPop;
  assign startReq    = blockMode ? (fifoCount >= CNT_W'(BLOCK_THRESH)) : !empty;
  // Popping the only word empties the FIFO unless a push refills it in the same cycle.
  assign lastWord    = (fifoCount == CNT_W'(1)) && !wrEn;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      DREQ         <= 1'b0;
      blockLatched <= 1'b0;
      overflow     <= 1'b0;
      xferCount    <= '0;
    end else begin
      if (pushDropped) overflow  <= 1'b1;
      if (doPop)       xferCount <= xferCount + 8'd1;

      // DREQ is written alongside every state change so it is high exactly in REQ and ACK.
      unique case (state)
        IDLE: begin
          if (startReq) begin
            state        <= REQ;
            DREQ         <= 1'b1;
            blockLatched <= blockMode;
          end
        end
        REQ: begin
          if (EOP) begin
            state <= RELEASE;
            DREQ  <= 1'b0;
          end else if (DACK) begin
            state <= ACK;
          end
        end
        ACK: begin
          if (EOP || (doPop && (!blockLatched || lastWord))) begin
            state <= RELEASE;
            DREQ  <= 1'b0;
          end else if (!DACK) begin
            state <= REQ;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          DREQ  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_request_agent.sv
// Self-checking bench for dma_request_agent: directed handshake scenarios plus random traffic,
// all compared against a queue-based behavioural model of the agent.
module tb_dma_request_agent;

  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int THRESH = 4;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_ACK  = 2;
  localparam int M_REL  = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          wrEn = 1'b0;
  logic [DW-1:0] wrData = '0;
  logic          blockMode = 1'b0;
  logic          DACK = 1'b0;
  logic          IOR = 1'b0;
  logic          EOP = 1'b0;
  logic          DREQ;
  logic [DW-1:0] dataOut;
  logic          dataOutEn;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    xferCount;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Behavioural model: a word queue plus the handshake phase.
  logic [DW-1:0] mq[$];
  int            mState = M_IDLE;
  bit            mBlock = 1'b0;
  bit            mOvf   = 1'b0;
  int            mXfer  = 0;

  dma_request_agent #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .BLOCK_THRESH(THRESH)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .wrEn     (wrEn),
    .wrData   (wrData),
    .blockMode(blockMode),
    .DACK     (DACK),
    .IOR      (IOR),
    .EOP      (EOP),
    .DREQ     (DREQ),
    .dataOut  (dataOut),
    .dataOutEn(dataOutEn),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .xferCount(xferCount)
  );

  always #5 CLK = ~CLK;

  assert property (@(posedge CLK)
    (dut.state == dmaAgentPkg::IDLE || dut.state == dmaAgentPkg::RELEASE) |-> !DREQ)
    else $error("FAIL dreqIdleRelease got DREQ=1 required 0");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h expected=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic modelEdge(input bit rst, input bit w, input logic [DW-1:0] d,
                           input bit bm, input bit dack, input bit ior, input bit eop);
    bit popOk;
    bit pushOk;
    int after;
    if (rst) begin
      mq.delete();
      mState = M_IDLE;
      mBlock = 1'b0;
      mOvf   = 1'b0;
      mXfer  = 0;
      return;
    end
    popOk  = (mState == M_ACK) && dack && ior && (mq.size() > 0);
    pushOk = w && ((mq.size() < DEPTH) || popOk);
    if (w && !pushOk) mOvf = 1'b1;
    after = mq.size() - int'(popOk) + int'(pushOk);
    case (mState)
      M_IDLE: if (bm ? (mq.size() >= THRESH) : (mq.size() >= 1)) begin
        mState = M_REQ;
        mBlock = bm;
      end
      M_REQ: if (eop) mState = M_REL; else if (dack) mState = M_ACK;
      M_ACK: begin
        if (eop) mState = M_REL;
        else if (popOk) mState = (!mBlock || after == 0) ? M_REL : M_ACK;
        else if (!dack) mState = M_REQ;
      end
      default: mState = M_IDLE;
    endcase
    if (popOk) begin
      void'(mq.pop_front());
      mXfer = (mXfer + 1) % 256;
    end
    if (pushOk) mq.push_back(d);
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare 1 time unit later.
  task automatic tick(input bit rst, input bit w, input logic [DW-1:0] d,
                      input bit bm, input bit dack, input bit ior, input bit eop);
    logic [DW-1:0] expHead;
    RESET = rst; wrEn = w; wrData = d; blockMode = bm; DACK = dack; IOR = ior; EOP = eop;
    @(posedge CLK);
    modelEdge(rst, w, d, bm, dack, ior, eop);
    #1;
    expHead = (mq.size() > 0) ? mq[0] : '0;
    check("DREQ", DREQ, (mState == M_REQ || mState == M_ACK));
    check("dataOutEn", dataOutEn, (mState == M_ACK) && dack);
    check("dataOut", dataOut, expHead);
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("overflow", overflow, mOvf);
    check("xferCount", xferCount, mXfer);
    @(negedge CLK);
  endtask

  task automatic idle(input bit bm);
    tick(1'b0, 1'b0, '0, bm, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushWord(input logic [DW-1:0] d, input bit bm);
    tick(1'b0, 1'b1, d, bm, 1'b0, 1'b0, 1'b0);
  endtask

  // Complete one single-mode request: wait (bounded) for REQ, acknowledge, read one word.
  task automatic serviceOne();
    int n = 0;
    while (mState != M_REQ && n < 8) begin
      idle(1'b0);
      n++;
    end
    if (mState != M_REQ) check("reqTimeout", DREQ, 1);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
  endtask

  task automatic applyReset();
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
  endtask

  initial begin
    @(negedge CLK);

    phase = "reset";
    applyReset();
    check("rstDREQ", DREQ, 0);
    check("rstEmpty", empty, 1);
    check("rstXfer", xferCount, 0);

    phase = "single";
    pushWord(8'hA5, 1'b0);
    check("noReqYet", DREQ, 0);
    idle(1'b0);
    check("dreqUp", DREQ, 1);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("head", dataOut, 8'hA5);
    check("drive", dataOutEn, 1);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("xfer1", xferCount, 1);
    check("released", DREQ, 0);
    check("drained", empty, 1);
    idle(1'b0);
    check("backIdle", 32'(dut.state), 0);

    phase = "block";
    for (int i = 0; i < 3; i++) pushWord(8'h30 + 8'(i), 1'b1);
    idle(1'b1);
    check("belowThresh", DREQ, 0);
    pushWord(8'h33, 1'b1);
    idle(1'b1);
    check("atThresh", DREQ, 1);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("order", dataOut, 8'h30 + 8'(i));
      tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (i < 3) tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("blockRelease", DREQ, 0);
    idle(1'b1);

    phase = "eop";
    for (int i = 0; i < 4; i++) pushWord(8'h50 + 8'(i), 1'b1);
    idle(1'b1);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("eopXfer", xferCount, 8'd7);
    check("eopRelease", DREQ, 0);
    idle(1'b1);
    check("remainHead", dataOut, 8'h52);
    idle(1'b0);
    check("reRequest", DREQ, 1);
    serviceOne();
    serviceOne();

    phase = "overflow";
    for (int i = 0; i < 4; i++) pushWord(8'h60 + 8'(i), 1'b0);
    check("isFull", full, 1);
    pushWord(8'h11, 1'b0);
    check("ovfSet", overflow, 1);
    check("stillFull", full, 1);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pushPopFull", full, 1);
    check("ovfSticky", overflow, 1);
    check("headAfter", dataOut, 8'h61);
    for (int i = 0; i < 4; i++) serviceOne();

    phase = "dackDrop";
    pushWord(8'h77, 1'b0);
    idle(1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("backToReq", 32'(dut.state), 1);
    check("dreqHeld", DREQ, 1);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("midAckState", 32'(dut.state), 0);
    check("midAckDREQ", DREQ, 0);
    check("midAckEn", dataOutEn, 0);
    check("midAckEmpty", empty, 1);
    check("midAckOvf", overflow, 0);
    check("midAckData", dataOut, 0);
    idle(1'b0);

    phase = "wrap";
    for (int i = 0; i < 256; i++) begin
      pushWord(8'(i), 1'b0);
      serviceOne();
      if (i == 254) check("xfer255", xferCount, 8'd255);
    end
    check("xferWrap", xferCount, 0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(99) == 0), ($urandom_range(1) == 1), 8'($urandom),
           ($urandom_range(1) == 1), ($urandom_range(9) < 6), ($urandom_range(1) == 1),
           ($urandom_range(9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
